// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive 4-row sweep of a two-input function with per-row response check
module tt_sweep_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] exp_s1,
  input  logic [3:0] exp_s2,
  input  logic       s1,
  input  logic       s2,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] table_s1,
  output logic [3:0] table_s2
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, FINISH} state_t;

  state_t     state, state_nx;
  logic [1:0] row;
  logic [3:0] settle_cnt;
  logic [3:0] exp_s1_q, exp_s2_q;
  logic       mismatch;

  assign mismatch = (s1 != exp_s1_q[row]) || (s2 != exp_s2_q[row]);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = DRIVE;
      DRIVE: begin
        busy     = 1'b1;
        state_nx = (SETTLE == 0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        // counter is about to reach zero on this edge
        if (settle_cnt <= 4'd1) state_nx = SAMPLE;
      end
      SAMPLE: begin
        busy     = 1'b1;
        state_nx = (row == 2'd3) ? FINISH : DRIVE;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= 2'd0;
      settle_cnt <= 4'd0;
      exp_s1_q   <= 4'd0;
      exp_s2_q   <= 4'd0;
      x          <= 1'b0;
      y          <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      table_s1   <= 4'd0;
      table_s2   <= 4'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            exp_s1_q  <= exp_s1;
            exp_s2_q  <= exp_s2;
            row       <= 2'd0;
            x         <= 1'b0;
            y         <= 1'b0;
            err_count <= 3'd0;
            table_s1  <= 4'd0;
            table_s2  <= 4'd0;
            pass      <= 1'b0;
          end
        end
        DRIVE: settle_cnt <= 4'(SETTLE);
        WAIT:  settle_cnt <= settle_cnt - 4'd1;
        SAMPLE: begin
          table_s1[row] <= s1;
          table_s2[row] <= s2;
          if (mismatch && err_count < 3'd4) err_count <= err_count + 3'd1;
          if (row == 2'd3) begin
            pass <= (err_count == 3'd0) && !mismatch;
          end else begin
            row      <= row + 2'd1;
            {x, y}   <= row + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - table-driven and randomized checks of tt_sweep_checker with SETTLE=1 and SETTLE=0
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       start [2];
  logic [3:0] exp1 [2];
  logic [3:0] exp2 [2];
  logic       s1 [2];
  logic       s2 [2];
  logic       x [2];
  logic       y [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [2:0] err [2];
  logic [3:0] t1 [2];
  logic [3:0] t2 [2];
  logic [3:0] fn1 [2];
  logic [3:0] fn2 [2];

  int passed = 0;
  int total  = 0;
  logic [1:0] xy_log [$];

  always #5 clk = ~clk;

  // Downstream function under test: a truth table indexed by {x,y}
  assign s1[0] = fn1[0][{x[0], y[0]}];
  assign s2[0] = fn2[0][{x[0], y[0]}];
  assign s1[1] = fn1[1][{x[1], y[1]}];
  assign s2[1] = fn2[1][{x[1], y[1]}];

  tt_sweep_checker #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .exp_s1(exp1[0]), .exp_s2(exp2[0]),
    .s1(s1[0]), .s2(s2[0]), .x(x[0]), .y(y[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err[0]), .table_s1(t1[0]), .table_s2(t2[0]));

  tt_sweep_checker #(.SETTLE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .exp_s1(exp1[1]), .exp_s2(exp2[1]),
    .s1(s1[1]), .s2(s2[1]), .x(x[1]), .y(y[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err[1]), .table_s1(t1[1]), .table_s2(t2[1]));

  typedef struct {
    int         sel;
    logic [3:0] e1, e2, f1, f2;
    logic [3:0] t1, t2;
    int         err;
    logic       pass;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic int settle_of(input int sel);
    return (sel == 0) ? 1 : 0;
  endfunction

  // Expectations are corrupted right after the start edge; they must not matter
  task automatic run_sweep(input int sel, input logic [3:0] e1, e2, f1, f2, output int lat);
    fn1[sel] = f1;
    fn2[sel] = f2;
    @(negedge clk);
    start[sel] = 1'b1; exp1[sel] = e1; exp2[sel] = e2;
    @(posedge clk);
    #1;
    start[sel] = 1'b0; exp1[sel] = ~e1; exp2[sel] = ~e2;
    lat = 0;
    xy_log.delete();
    while (!done[sel] && lat < 100) begin
      @(negedge clk);
      lat++;
      xy_log.push_back({x[sel], y[sel]});
    end
  endtask

  task automatic check_sweep(input int sel, input int lat, input logic [3:0] rt1, rt2,
                             input int rerr, input logic rpass);
    int s;
    int bad;
    s = settle_of(sel);
    chk("latency", lat, 4 * (s + 2) + 1);
    chk("busy_at_done", int'(busy[sel]), 0);
    chk("table_s1", int'(t1[sel]), int'(rt1));
    chk("table_s2", int'(t2[sel]), int'(rt2));
    chk("err_count", int'(err[sel]), rerr);
    chk("pass", int'(pass[sel]), int'(rpass));
    bad = 0;
    for (int i = 0; i < 4 * (s + 2) && i < xy_log.size(); i++)
      if (int'(xy_log[i]) != i / (s + 2)) bad++;
    chk("xy_sequence_errors", bad, 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done[sel]), 0);
  endtask

  initial begin
    int lat;
    int ndone;
    int model_err;
    logic [3:0] re1, re2, rf1, rf2;

    // {sel, e1, e2, f1, f2, table_s1, table_s2, err, pass}; 4'b1101 is x|~y
    vt[0] = '{0, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 0, 1'b1};
    vt[1] = '{0, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 1, 1'b0};
    vt[2] = '{0, 4'b0010, 4'b0010, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4, 1'b0};
    vt[3] = '{1, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 0, 1'b1};
    vt[4] = '{1, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 0, 1'b1};
    vt[5] = '{1, 4'b0111, 4'b0000, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 2, 1'b0};
    vt[6] = '{0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4, 1'b0};
    vt[7] = '{1, 4'b1010, 4'b0101, 4'b1010, 4'b0100, 4'b1010, 4'b0100, 1, 1'b0};

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; exp1[i] = 4'hF; exp2[i] = 4'hF;
      fn1[i] = 4'h0; fn2[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", int'({x[i], y[i], busy[i], done[i], pass[i], err[i], t1[i], t2[i]}), 0);

    foreach (vt[i]) begin
      run_sweep(vt[i].sel, vt[i].e1, vt[i].e2, vt[i].f1, vt[i].f2, lat);
      check_sweep(vt[i].sel, lat, vt[i].t1, vt[i].t2, vt[i].err, vt[i].pass);
    end

    // Idle holds results even when responses and expectations move
    fn1[1] = 4'b0000; fn2[1] = 4'b1111; exp1[1] = 4'h0; exp2[1] = 4'h0;
    repeat (5) @(negedge clk);
    chk("idle_hold_xy", int'({x[1], y[1]}), 3);
    chk("idle_hold_table_s1", int'(t1[1]), 4'b1010);
    chk("idle_hold_err", int'(err[1]), 1);
    chk("idle_hold_busy", int'(busy[1]), 0);

    // Reset while row 2 is driven: no done pulse, everything cleared
    fn1[0] = 4'b0000; fn2[0] = 4'b0000;
    @(negedge clk);
    start[0] = 1'b1; exp1[0] = 4'hF; exp2[0] = 4'hF;
    @(posedge clk);
    #1 start[0] = 1'b0;
    lat = 0;
    while (!({x[0], y[0]} == 2'b10) && lat < 50) begin @(negedge clk); lat++; end
    chk("reached_row2", int'(lat < 50), 1);
    chk("err_before_abort", int'(err[0]), 2);
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1 rst_n[0] = 1'b1;
    chk("abort_outputs", int'({x[0], y[0], busy[0], done[0], pass[0], err[0], t1[0], t2[0]}), 0);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done[0]) ndone++; end
    chk("abort_no_done", ndone, 0);
    run_sweep(0, 4'b1101, 4'b1101, 4'b1101, 4'b1101, lat);
    check_sweep(0, lat, 4'b1101, 4'b1101, 0, 1'b1);

    // Reset overrides start on the same edge
    @(negedge clk);
    rst_n[1] = 1'b0; start[1] = 1'b1;
    @(posedge clk);
    #1 rst_n[1] = 1'b1; start[1] = 1'b0;
    @(negedge clk);
    chk("reset_beats_start", int'(busy[1]), 0);

    // start held through busy and FINISH with new expectations: one done, first latch wins
    fn1[1] = 4'b1101; fn2[1] = 4'b1101;
    @(negedge clk);
    start[1] = 1'b1; exp1[1] = 4'b1101; exp2[1] = 4'b1101;
    @(posedge clk);
    #1 exp1[1] = 4'b0010; exp2[1] = 4'b0010;
    ndone = 0;
    lat = 0;
    while (!done[1] && lat < 100) begin @(negedge clk); lat++; end
    chk("hold_start_latency", lat, 9);
    if (done[1]) ndone++;
    chk("hold_start_err", int'(err[1]), 0);
    chk("hold_start_pass", int'(pass[1]), 1);
    start[1] = 1'b0;
    repeat (20) begin @(negedge clk); if (done[1]) ndone++; end
    chk("hold_start_one_done", ndone, 1);

    // Randomized sweeps against a truth-table comparison model
    for (int k = 0; k < 24; k++) begin
      re1 = 4'($urandom); re2 = 4'($urandom);
      rf1 = 4'($urandom); rf2 = 4'($urandom);
      if (k % 4 == 0) begin re1 = rf1; re2 = rf2; end
      model_err = $countones((rf1 ^ re1) | (rf2 ^ re2));
      run_sweep(k % 2, re1, re2, rf1, rf2, lat);
      check_sweep(k % 2, lat, rf1, rf2, model_err, model_err == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
